// File: rtl/banked_memory_pkg.sv
// Shared types and helpers for the banked CPU memory.
package banked_memory_pkg;

   localparam int WAIT_CNT_W      = 4;
   localparam int WAIT_STATES_MAX = 15;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_LOAD  = 3'd1,
      ST_IDLE  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // The address MSB picks the bank: 0 = RAM, 1 = ROM.
   function automatic logic is_rom_bank(input logic addr_msb);
      return addr_msb;
   endfunction

endpackage

// File: rtl/banked_memory_bank.sv
// Single-port storage array: synchronous write, combinational read, no reset.
module banked_memory_bank #(
   parameter int DATA_W = 8,
   parameter int AW     = 7
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);
   localparam int DEPTH = 2**AW;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/banked_memory.sv
// Banked CPU memory: RAM (addr MSB=0) with post-reset clear, write-protected
// ROM (addr MSB=1) filled by a streaming boot-load port, and a req/ack CPU
// port with programmable wait states.
//
// state | meaning
// CLEAR | zeroing RAM, one word per cycle; CPU port ignored
// LOAD  | accepting boot-load words into ROM
// IDLE  | waiting for a CPU request
// WAIT  | counting wait states after acceptance
// RESP  | one-cycle ack (and fault on ROM write)
module banked_memory
   import banked_memory_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_load,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_fault,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              busy
);
   localparam int BANK_AW = ADDR_W - 1;
   localparam logic [WAIT_CNT_W-1:0] WS = WAIT_STATES[WAIT_CNT_W-1:0];

   state_t r_state;
   state_t w_next;

   logic [BANK_AW-1:0]    r_ptr;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic [DATA_W-1:0]     r_rdata;
   logic                  r_fault;

   logic                  w_accept;
   logic                  w_rom_sel;
   logic                  w_ptr_last;
   logic                  w_load_hs;
   logic                  w_load_done;
   logic [BANK_AW-1:0]    w_cpu_addr;

   logic                  w_ram_we;
   logic [BANK_AW-1:0]    w_ram_addr;
   logic [DATA_W-1:0]     w_ram_wdata;
   logic [DATA_W-1:0]     w_ram_rdata;
   logic [BANK_AW-1:0]    w_rom_addr;
   logic [DATA_W-1:0]     w_rom_rdata;

   assign w_cpu_addr  = cpu_addr[BANK_AW-1:0];
   assign w_rom_sel   = is_rom_bank(cpu_addr[ADDR_W-1]);
   assign w_accept    = (r_state == ST_IDLE) && cpu_req;
   assign w_ptr_last  = &r_ptr;
   assign w_load_hs   = (r_state == ST_LOAD) && load_valid;
   assign w_load_done = w_load_hs && (load_last || w_ptr_last);

   // RAM is driven by the clear pointer during CLEAR, otherwise by the CPU.
   assign w_ram_we    = (r_state == ST_CLEAR) || (w_accept && cpu_we && !w_rom_sel);
   assign w_ram_addr  = (r_state == ST_CLEAR) ? r_ptr : w_cpu_addr;
   assign w_ram_wdata = (r_state == ST_CLEAR) ? '0 : cpu_wdata;

   // ROM only accepts writes from the load port; CPU writes just raise a fault.
   assign w_rom_addr  = (r_state == ST_LOAD) ? r_ptr : w_cpu_addr;

   banked_memory_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   banked_memory_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_rom (
      .clk     (clk),
      .i_we    (w_load_hs),
      .i_addr  (w_rom_addr),
      .i_wdata (load_data),
      .o_rdata (w_rom_rdata)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_next;
      end
   end

   // Shared clear/load pointer; CLEAR ends wrapped to 0, ready for LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_load_done) begin
         r_ptr <= '0;
      end else if ((r_state == ST_CLEAR) || w_load_hs) begin
         r_ptr <= r_ptr + BANK_AW'(1);
      end
   end

   // Wait-state down-counter, loaded on acceptance, terminal count at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (w_accept) begin
         r_wait_cnt <= WS - WAIT_CNT_W'(1);
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
         r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
      end
   end

   // Read data and fault flag are captured on the acceptance edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
         r_fault <= 1'b0;
      end else if (w_accept) begin
         r_fault <= cpu_we && w_rom_sel;
         if (!cpu_we) begin
            r_rdata <= w_rom_sel ? w_rom_rdata : w_ram_rdata;
         end
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_next     = r_state;
      cpu_ack    = 1'b0;
      cpu_fault  = 1'b0;
      load_ready = 1'b0;
      busy       = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            busy = 1'b1;
            if (w_ptr_last) begin
               w_next = boot_load ? ST_LOAD : ST_IDLE;
            end
         end
         ST_LOAD: begin
            busy       = 1'b1;
            load_ready = 1'b1;
            if (w_load_done) begin
               w_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (cpu_req) begin
               w_next = (WS != '0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            cpu_ack   = 1'b1;
            cpu_fault = r_fault;
            w_next    = ST_IDLE;
         end
         default: w_next = ST_CLEAR;
      endcase
   end

   assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench: one instance with no wait states, one with three, sharing
// clock, reset and the boot-load stream.
module tb_banked_memory;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       boot_load = 1'b0;
   logic       load_valid = 1'b0;
   logic       load_last = 1'b0;
   logic [7:0] load_data = 8'h00;

   logic       req0 = 1'b0, we0 = 1'b0;
   logic [7:0] addr0 = 8'h00, wdata0 = 8'h00;
   logic [7:0] rd0;
   logic       ack0, flt0, lr0, busy0;

   logic       req3 = 1'b0, we3 = 1'b0;
   logic [7:0] addr3 = 8'h00, wdata3 = 8'h00;
   logic [7:0] rd3;
   logic       ack3, flt3, lr3, busy3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   banked_memory #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .boot_load(boot_load),
      .cpu_req(req0), .cpu_we(we0), .cpu_addr(addr0), .cpu_wdata(wdata0),
      .cpu_rdata(rd0), .cpu_ack(ack0), .cpu_fault(flt0),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(lr0), .busy(busy0)
   );

   banked_memory #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .boot_load(boot_load),
      .cpu_req(req3), .cpu_we(we3), .cpu_addr(addr3), .cpu_wdata(wdata3),
      .cpu_rdata(rd3), .cpu_ack(ack3), .cpu_fault(flt3),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(lr3), .busy(busy3)
   );

   typedef struct {
      int         d;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       fault;
      int         lat;
   } vec_t;

   localparam int NV = 15;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic boot);
      @(posedge clk); #1;
      rst_n = 1'b0;
      boot_load = boot;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Edges from reset release until the instance leaves CLEAR.
   task automatic count_clear(input logic to_load, output int n);
      n = 0;
      while (n < 1000 && (to_load ? !lr0 : busy0)) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic stream(input logic [7:0] data, input logic last);
      load_valid = 1'b1;
      load_data  = data;
      load_last  = last;
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // One access; lat counts edges from acceptance to the cycle ack is seen.
   task automatic do_access(input int d, input logic w, input logic [7:0] a,
                            input logic [7:0] wd, output logic [7:0] rd,
                            output logic flt, output int lat);
      int cyc;
      if (d == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
      else        begin req3 = 1'b1; we3 = w; addr3 = a; wdata3 = wd; end
      lat = -1;
      rd  = 8'h00;
      flt = 1'b0;
      cyc = 1;
      @(posedge clk); #1;
      while (cyc <= 40) begin
         if ((d == 0) ? ack0 : ack3) begin
            lat = cyc;
            rd  = (d == 0) ? rd0 : rd3;
            flt = (d == 0) ? flt0 : flt3;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      req0 = 1'b0;
      req3 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int         n, lat;
      logic [7:0] rd, a;
      logic       flt;

      vec[0]  = '{0, 1'b0, 8'h81, 8'h00, 8'hA1, 1'b0, 1};
      vec[1]  = '{0, 1'b0, 8'h80, 8'h00, 8'hA0, 1'b0, 1};
      vec[2]  = '{0, 1'b1, 8'h10, 8'h5C, 8'hA0, 1'b0, 1};
      vec[3]  = '{0, 1'b0, 8'h10, 8'h00, 8'h5C, 1'b0, 1};
      vec[4]  = '{0, 1'b1, 8'h82, 8'hFF, 8'h5C, 1'b1, 1};
      vec[5]  = '{0, 1'b0, 8'h82, 8'h00, 8'hA2, 1'b0, 1};
      vec[6]  = '{0, 1'b1, 8'h7F, 8'h3C, 8'hA2, 1'b0, 1};
      vec[7]  = '{0, 1'b1, 8'h00, 8'hC3, 8'hA2, 1'b0, 1};
      vec[8]  = '{0, 1'b0, 8'h7F, 8'h00, 8'h3C, 1'b0, 1};
      vec[9]  = '{0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 1};
      vec[10] = '{3, 1'b1, 8'h10, 8'h5C, 8'h00, 1'b0, 4};
      vec[11] = '{3, 1'b0, 8'h10, 8'h00, 8'h5C, 1'b0, 4};
      vec[12] = '{3, 1'b1, 8'h82, 8'hFF, 8'h5C, 1'b1, 4};
      vec[13] = '{3, 1'b0, 8'h82, 8'h00, 8'hA2, 1'b0, 4};
      vec[14] = '{3, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 4};

      // Outputs while reset is held.
      #1;
      chk("rst_busy", busy0, 1);
      chk("rst_ack", ack0, 0);
      chk("rst_fault", flt0, 0);
      chk("rst_rdata", rd0, 0);
      chk("rst_load_ready", lr0, 0);

      // Dirty some RAM, then reset and confirm it is cleared.
      @(posedge clk); #1;
      rst_n = 1'b1;
      count_clear(1'b0, n);
      chk("clear1_len", n, 128);
      do_access(0, 1'b1, 8'h00, 8'h5A, rd, flt, lat);
      do_access(0, 1'b1, 8'h7F, 8'h33, rd, flt, lat);
      do_access(0, 1'b1, 8'h40, 8'h11, rd, flt, lat);
      do_access(0, 1'b0, 8'h40, 8'h00, rd, flt, lat);
      chk("dirty_rd", rd, 8'h11);

      do_reset(1'b0);
      count_clear(1'b0, n);
      chk("clear2_len", n, 128);
      for (int i = 0; i < 128; i++) begin
         a = 8'(i);
         do_access(0, 1'b0, a, 8'h00, rd, flt, lat);
         chk($sformatf("clr_rd_%0h", a), rd, 8'h00);
      end

      // Boot load of three words.
      do_reset(1'b1);
      count_clear(1'b1, n);
      chk("clear3_len", n, 128);
      stream(8'hA0, 1'b0);
      chk("load_busy1", busy0, 1);
      stream(8'hA1, 1'b0);
      chk("load_busy2", busy0, 1);
      stream(8'hA2, 1'b1);
      chk("load_busy3", busy0, 0);
      chk("load_ready3", lr0, 0);

      for (int k = 0; k < NV; k++) begin
         do_access(vec[k].d, vec[k].we, vec[k].addr, vec[k].wdata, rd, flt, lat);
         chk($sformatf("v%0d_lat", k), lat, vec[k].lat);
         chk($sformatf("v%0d_rdata", k), rd, vec[k].rdata);
         chk($sformatf("v%0d_fault", k), flt, vec[k].fault);
      end

      // Request held continuously: ack on every second cycle.
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h81;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         chk($sformatf("cont_ack%0d", i), ack0, (i % 2) == 1);
      end
      chk("cont_rdata", rd0, 8'hA1);
      req0 = 1'b0;
      @(posedge clk); #1;

      // Async reset in the middle of a wait-stated read.
      req3 = 1'b1; we3 = 1'b0; addr3 = 8'h81;
      @(posedge clk); #1;
      chk("mid_rdata_cap", rd3, 8'hA1);
      rst_n = 1'b0;
      boot_load = 1'b1;
      #1;
      chk("mid_rst_rdata", rd3, 8'h00);
      chk("mid_rst_ack", ack3, 0);
      chk("mid_rst_busy", busy3, 1);
      req3 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset after two load words: CLEAR restarts, ROM kept, pointer back to 0.
      count_clear(1'b1, n);
      chk("clear4_len", n, 128);
      stream(8'hB0, 1'b0);
      stream(8'hB1, 1'b0);
      @(posedge clk); #1;
      chk("load_wait_ready", lr0, 1);
      do_reset(1'b1);
      count_clear(1'b1, n);
      chk("clear5_len", n, 128);
      stream(8'hC0, 1'b1);
      chk("reload_busy", busy0, 0);
      do_access(0, 1'b0, 8'h80, 8'h00, rd, flt, lat);
      chk("reload_rom0", rd, 8'hC0);
      do_access(0, 1'b0, 8'h81, 8'h00, rd, flt, lat);
      chk("reload_rom1", rd, 8'hB1);
      do_access(0, 1'b0, 8'h82, 8'h00, rd, flt, lat);
      chk("reload_rom2", rd, 8'hA2);
      do_access(3, 1'b0, 8'h81, 8'h00, rd, flt, lat);
      chk("reload_rom1_ws3", rd, 8'hB1);
      chk("reload_lat_ws3", lat, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/banked_memory.md
# banked_memory

Parametrised successor to the 8-bit CPU memory: a unified address space split by the address MSB into a writable RAM bank (MSB=0) and a write-protected ROM bank (MSB=1). Adds a request/acknowledge CPU port with programmable wait states, a hardware RAM clear after reset, and a streaming boot-load port that fills ROM before the CPU is released. Sits between the CPU core and its program/data store.

## Interface
- DATA_W, 8, data word width
- ADDR_W, 8, CPU address width; each bank is 2**(ADDR_W-1) words
- WAIT_STATES, 0, extra cycles inserted between acceptance and ack (0..15)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- boot_load  in  1  sampled at end of CLEAR; 1 enters LOAD, 0 enters IDLE
- cpu_req  in  1  access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  word address; MSB selects bank
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1; reset 0
- cpu_ack  out  1  one-cycle completion pulse; reset 0
- cpu_fault  out  1  pulses with cpu_ack on a write to ROM; reset 0
- load_valid  in  1  ROM load word present
- load_data  in  DATA_W  ROM load word
- load_last  in  1  marks final load word
- load_ready  out  1  high only in LOAD; reset 0
- busy  out  1  high in CLEAR and LOAD; reset 1

## Operation
- States: CLEAR, LOAD, IDLE, WAIT, RESP. Reset → CLEAR.
- CLEAR: clear pointer 0..2**(ADDR_W-1)-1 writes 0 to RAM, one word per cycle; after the last word, go to LOAD if boot_load=1, else IDLE. cpu_req ignored (no ack).
- LOAD: each cycle with load_valid & load_ready writes load_data to ROM[ptr], ptr++. Exit to IDLE after the handshake carrying load_last, or after the word written at ptr = max (wrap); extra words are not accepted.
- IDLE: cpu_req=1 accepts the access. RAM write commits on the acceptance edge. ROM write: array unchanged, cpu_fault set. Read: bank word captured into cpu_rdata register on acceptance edge. Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: counts WAIT_STATES cycles, then RESP.
- RESP: cpu_ack=1 (cpu_fault if applicable) for exactly one cycle; → IDLE. A request still high in IDLE after ack is a new access.
- Arrays have no reset; ROM contents survive rst_n. Reset mid-CLEAR or mid-LOAD restarts at CLEAR; LOAD pointer returns to 0.
- Async reset asserted mid-access drops the access; cpu_ack, cpu_fault, cpu_rdata go to 0 immediately.

## Timing
- Read/write latency: ack on cycle 1+WAIT_STATES after acceptance edge; access period 2+WAIT_STATES cycles.
- Read-after-write to same address in consecutive accesses returns new data.
- CLEAR lasts exactly 2**(ADDR_W-1) cycles; busy falls the cycle IDLE is entered.
- cpu_rdata holds last read value until the next read is accepted.

## Structure
- Package banked_memory_pkg: state enum typedef, bank-select helper (MSB test), WAIT_STATES max constant.
- One sub-module natural: banked_memory_bank (single-port array, sync write, combinational read, parametrised DATA_W/depth), instantiated twice; top holds FSM, counters, load port.

## Test plan
- Reset, boot_load=0, ADDR_W=8 → busy high 128 cycles, then reads of 0x00..0x7F all return 0.
- boot_load=1, stream 0xA0,0xA1,0xA2 with load_last on third → ROM[0..2]=A0..A2; read 0x81 returns 0xA1; busy falls after third handshake.
- WAIT_STATES=3: write 0x5C to 0x10, read 0x10 → each ack exactly 4 cycles after acceptance, rdata 0x5C.
- Write 0xFF to 0x82 after load → cpu_fault pulses with ack; read 0x82 still 0xA2.
- rst_n pulsed during LOAD after 2 words → CLEAR restarts, ROM[0..1] retained, load pointer restarts at 0.
- cpu_req held continuously with WAIT_STATES=0 → ack every 2nd cycle, no double ack per access.
